// File: rtl/uart_resp_arb.sv
// uart_resp_arb: arbitrates three requesters for a single UART response
// channel. A winner's byte is latched and handed to the UART wrapper with a
// one-cycle send_resp strobe; the channel is then held until the wrapper
// reports completion with resp_sent, at which point done is pulsed to the
// owner and arbitration resumes.
//
// Configuration macro: UART_RESP_ARB_RR_EN
//   defined   -> round-robin arbitration starting after the last grantee
//   undefined -> fixed priority 0 > 1 > 2 (last-grant pointer kept, unused)
module uart_resp_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  input  logic       resp_sent,
  output logic       send_resp,
  output logic [7:0] resp,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    XMIT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       send_resp_q, send_resp_d;
  logic [7:0] resp_q, resp_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] done_q, done_d;
  logic       busy_q, busy_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;

  logic [1:0] win;
  logic [7:0] win_byte;

`ifdef UART_RESP_ARB_RR_EN
  // Round-robin winner: search starts one past the last grantee, wrapping 2->0.
  always_comb begin
    win = 2'd0;
    case (last_q)
      2'd0: begin
        if      (req[1]) win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if      (req[2]) win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if      (req[0]) win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
  end
`else
  // Fixed-priority winner: requester 0 always beats 1, which beats 2.
  always_comb begin
    win = 2'd0;
    if      (req[0]) win = 2'd0;
    else if (req[1]) win = 2'd1;
    else             win = 2'd2;
  end
`endif

  // Select the winner's offered byte for latching into resp.
  always_comb begin
    case (win)
      2'd0:    win_byte = byte0;
      2'd1:    win_byte = byte1;
      default: win_byte = byte2;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/XMIT machine.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    send_resp_d = 1'b0;
    gnt_d       = 3'b000;
    done_d      = 3'b000;
    resp_d      = resp_q;
    busy_d      = busy_q;
    owner_d     = owner_q;
    last_d      = last_q;

    case (state_q)
      IDLE: begin
        // resp_sent is meaningless here and is deliberately not looked at.
        if (|req) begin
          state_d     = XMIT;
          send_resp_d = 1'b1;
          gnt_d       = 3'b001 << win;
          resp_d      = win_byte;
          busy_d      = 1'b1;
          owner_d     = win;
          last_d      = win;
        end
      end
      XMIT: begin
        // A resp_sent landing in the strobe cycle belongs to an earlier
        // transfer, so completion is only accepted once the strobe is gone.
        if (resp_sent && !send_resp_q) begin
          state_d = IDLE;
          done_d  = 3'b001 << owner_q;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, asynchronously cleared by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled before the edge.
    if (!rst_n) begin
      state_q     <= IDLE;
      send_resp_q <= 1'b0;
      gnt_q       <= 3'b000;
      done_q      <= 3'b000;
      resp_q      <= 8'h00;
      busy_q      <= 1'b0;
      owner_q     <= 2'd0;
      last_q      <= 2'd2;
    end else begin
      state_q     <= state_d;
      send_resp_q <= send_resp_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      resp_q      <= resp_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
    end
  end

  assign send_resp = send_resp_q;
  assign resp      = resp_q;
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_resp_arb.sv
// tb_uart_resp_arb: directed bench for uart_resp_arb. Inputs change 1 ns after
// the rising edge; outputs are compared at the same point or on falling edges.
module tb_uart_resp_arb;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic [7:0] byte2;
  logic       resp_sent;
  logic       send_resp;
  logic [7:0] resp;
  logic [2:0] gnt;
  logic [2:0] done;
  logic       busy;

  int checks = 0;
  int passed = 0;

  uart_resp_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .byte0     (byte0),
    .byte1     (byte1),
    .byte2     (byte2),
    .resp_sent (resp_sent),
    .send_resp (send_resp),
    .resp      (resp),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gnt and done each one-hot or zero, never both active together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((gnt & (gnt - 3'd1)) != 3'd0 || (done & (done - 3'd1)) != 3'd0 ||
          (|gnt && |done)) begin
        $display("FAIL onehot_excl: gnt=%b done=%b, required one-hot/zero and exclusive", gnt, done);
      end else begin
        passed++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b000; resp_sent = 1'b0;
    byte0 = 8'h00; byte1 = 8'h00; byte2 = 8'h00;
    #3;
    checks++;
    if ({send_resp, gnt, done, busy, resp} !== 16'h0000)
      $display("FAIL reset_outputs: send=%b gnt=%b done=%b busy=%b resp=%h, required all zero",
               send_resp, gnt, done, busy, resp);
    else passed++;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({send_resp, gnt, busy} !== 5'b0)
      $display("FAIL idle_after_reset: send=%b gnt=%b busy=%b, required zero", send_resp, gnt, busy);
    else passed++;
  endtask

  task automatic test_single();
    bit stable;
    req = 3'b010; byte1 = 8'hA5;
    step();
    checks++;
    if (gnt !== 3'b010 || send_resp !== 1'b1 || resp !== 8'hA5 || busy !== 1'b1 || done !== 3'b000)
      $display("FAIL single_grant: gnt=%b send=%b resp=%h busy=%b done=%b, required 010 1 a5 1 000",
               gnt, send_resp, resp, busy, done);
    else passed++;
    req = 3'b000;
    stable = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step();
      if (gnt !== 3'b000 || send_resp !== 1'b0 || resp !== 8'hA5 || busy !== 1'b1 || done !== 3'b000)
        stable = 1'b0;
    end
    checks++;
    if (!stable)
      $display("FAIL single_hold: outputs changed during XMIT, required gnt=0 send=0 resp=a5 busy=1");
    else passed++;
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    checks++;
    if (done !== 3'b010 || busy !== 1'b0 || resp !== 8'hA5)
      $display("FAIL single_done: done=%b busy=%b resp=%h, required 010 0 a5", done, busy, resp);
    else passed++;
    step();
    checks++;
    if (done !== 3'b000 || send_resp !== 1'b0)
      $display("FAIL single_done_pulse: done=%b send=%b, required 000 0", done, send_resp);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_byte [3];
    exp_byte[0] = 8'h11; exp_byte[1] = 8'h22; exp_byte[2] = 8'h33;
    byte0 = 8'h11; byte1 = 8'h22; byte2 = 8'h33;
    req = 3'b111;
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (send_resp !== 1'b1 || gnt !== (3'b001 << k) || resp !== exp_byte[k])
        $display("FAIL simul_grant%0d: send=%b gnt=%b resp=%h, required 1 %b %h",
                 k, send_resp, gnt, resp, 3'b001 << k, exp_byte[k]);
      else passed++;
      req[k] = 1'b0;
      step(); step(); step();
      resp_sent = 1'b1;
      step();
      resp_sent = 1'b0;
      checks++;
      if (done !== (3'b001 << k) || busy !== 1'b0)
        $display("FAIL simul_done%0d: done=%b busy=%b, required %b 0", k, done, busy, 3'b001 << k);
      else passed++;
      if (k < 2) step();
    end
    step();
    checks++;
    if (send_resp !== 1'b0 || busy !== 1'b0)
      $display("FAIL simul_quiet: send=%b busy=%b, required 0 0", send_resp, busy);
    else passed++;
  endtask

  task automatic test_priority();
    int exp_w [3];
`ifdef UART_RESP_ARB_RR_EN
    exp_w[0] = 0; exp_w[1] = 2; exp_w[2] = 0;
`else
    exp_w[0] = 0; exp_w[1] = 0; exp_w[2] = 0;
`endif
    byte0 = 8'hC0; byte2 = 8'hC2;
    req = 3'b101;
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (send_resp !== 1'b1 || gnt !== (3'b001 << exp_w[k]) ||
          resp !== ((exp_w[k] == 0) ? 8'hC0 : 8'hC2))
        $display("FAIL prio_grant%0d: send=%b gnt=%b resp=%h, required 1 %b", k, send_resp, gnt, resp,
                 3'b001 << exp_w[k]);
      else passed++;
      req[exp_w[k]] = 1'b0;
      step(); step();
      resp_sent = 1'b1;
      step();
      resp_sent = 1'b0;
      checks++;
      if (done !== (3'b001 << exp_w[k]))
        $display("FAIL prio_done%0d: done=%b, required %b", k, done, 3'b001 << exp_w[k]);
      else passed++;
      if (k < 2) begin
        req[exp_w[k]] = 1'b1;
        step();
      end else begin
        req = 3'b000;
      end
    end
    step();
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0)
      $display("FAIL prio_quiet: gnt=%b busy=%b, required 000 0", gnt, busy);
    else passed++;
  endtask

  task automatic test_spurious();
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    checks++;
    if (done !== 3'b000 || busy !== 1'b0 || send_resp !== 1'b0)
      $display("FAIL spur_idle: done=%b busy=%b send=%b, required 000 0 0", done, busy, send_resp);
    else passed++;
    req = 3'b001; byte0 = 8'h3C;
    step();
    checks++;
    if (send_resp !== 1'b1 || gnt !== 3'b001 || resp !== 8'h3C)
      $display("FAIL spur_grant: send=%b gnt=%b resp=%h, required 1 001 3c", send_resp, gnt, resp);
    else passed++;
    req = 3'b000;
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    checks++;
    if (done !== 3'b000 || busy !== 1'b1)
      $display("FAIL spur_strobe: done=%b busy=%b, required 000 1", done, busy);
    else passed++;
    step(); step();
    checks++;
    if (done !== 3'b000 || busy !== 1'b1 || send_resp !== 1'b0)
      $display("FAIL spur_wait: done=%b busy=%b send=%b, required 000 1 0", done, busy, send_resp);
    else passed++;
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    checks++;
    if (done !== 3'b001 || busy !== 1'b0)
      $display("FAIL spur_done: done=%b busy=%b, required 001 0", done, busy);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    req = 3'b010; byte1 = 8'h77;
    step();
    checks++;
    if (gnt !== 3'b010 || send_resp !== 1'b1 || resp !== 8'h77)
      $display("FAIL rmid_grant: gnt=%b send=%b resp=%h, required 010 1 77", gnt, send_resp, resp);
    else passed++;
    req = 3'b000;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({send_resp, gnt, done, busy, resp} !== 16'h0000)
      $display("FAIL rmid_async: send=%b gnt=%b done=%b busy=%b resp=%h, required all zero",
               send_resp, gnt, done, busy, resp);
    else passed++;
    step();
    rst_n = 1'b1;
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    checks++;
    if (done !== 3'b000 || busy !== 1'b0)
      $display("FAIL rmid_nodone: done=%b busy=%b, required 000 0", done, busy);
    else passed++;
    req = 3'b001; byte0 = 8'h42;
    step();
    checks++;
    if (gnt !== 3'b001 || send_resp !== 1'b1 || resp !== 8'h42 || busy !== 1'b1)
      $display("FAIL rmid_regrant: gnt=%b send=%b resp=%h busy=%b, required 001 1 42 1",
               gnt, send_resp, resp, busy);
    else passed++;
    req = 3'b000;
    step();
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    checks++;
    if (done !== 3'b001)
      $display("FAIL rmid_done: done=%b, required 001", done);
    else passed++;
    step();
  endtask

  task automatic test_byte_change();
    bit held;
    req = 3'b001; byte0 = 8'h5A;
    step();
    checks++;
    if (gnt !== 3'b001 || resp !== 8'h5A)
      $display("FAIL bchg_grant: gnt=%b resp=%h, required 001 5a", gnt, resp);
    else passed++;
    req = 3'b000; byte0 = 8'hFF;
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp !== 8'h5A) held = 1'b0;
    end
    checks++;
    if (!held)
      $display("FAIL bchg_hold: resp=%h, required 5a throughout XMIT", resp);
    else passed++;
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    checks++;
    if (done !== 3'b001 || resp !== 8'h5A)
      $display("FAIL bchg_done: done=%b resp=%h, required 001 5a", done, resp);
    else passed++;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_priority();
    test_spurious();
    test_reset_mid();
    test_byte_change();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
